fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined core, directly upstream of the fetch/decode pipeline register. Owns the program counter, drives a synchronous-read instruction memory (1-cycle read latency), and presents `f_pc`/`f_inst` plus the fetch/decode register update code (hold/load/flush). Handles downstream stalls, branch/jump redirects from execute, and a sticky halt.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_perf.sv | 31 +++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: pipeline-register update codes and fetch FSM states.
// Pure declarations, no logic; decode and execute stages reuse fd_update_t.
package fetch_pkg;

    typedef enum logic [1:0] {
        FD_HOLD  = 2'b00,
        FD_LOAD  = 2'b01,
        FD_FLUSH = 2'b10
    } fd_update_t;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Clears the byte-offset bits of a branch/jump target.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_perf.sv
// Fetch performance counters: loads, stalls and flushes seen while running.
// Latency: counts visible the cycle after the event; wrap modulo 2^32.
// Backpressure: none; observes fd_update only, counters freeze whenever run is low.
module fetch_perf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        run,
    input  fd_update_t  fd_update,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else if (run) begin
            case (fd_update)
                FD_LOAD:  perf_fetched <= perf_fetched + 32'd1;
                FD_HOLD:  perf_stall   <= perf_stall + 32'd1;
                FD_FLUSH: perf_flush   <= perf_flush + 32'd1;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives a 1-cycle sync-read imem, feeds the F/D register.
// Latency: first valid fetch one cycle after BOOT; 1 inst/cycle sustained; redirect costs 1 bubble.
// Backpressure: stall holds F/D and re-reads the same word so imem_rdata stays stable.
// Optional counters under FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 15
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        f_pc,
    output logic [31:0]        f_inst,
    output logic               f_valid,
    output logic [1:0]         fd_update
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  req_pc, req_pc_nxt;
    logic [31:0]  addr_pc;
    logic [31:0]  pc_inc;
    logic [31:0]  redir_tgt;
    fd_update_t   upd;

    assign pc_inc    = req_pc + PC_STEP;
    assign redir_tgt = word_align(redirect_pc);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= BOOT;
            req_pc <= RESET_PC;
        end else begin
            state  <= state_nxt;
            req_pc <= req_pc_nxt;
        end
    end

    // imem_addr depends only on state, req_pc and control inputs, never on imem_rdata.
    always_comb begin
        state_nxt  = state;
        req_pc_nxt = req_pc;
        addr_pc    = req_pc;
        upd        = FD_FLUSH;
        f_valid    = 1'b0;
        f_pc       = 32'h0;
        f_inst     = INST_NOP;
        case (state)
            BOOT: begin
                addr_pc    = RESET_PC;
                req_pc_nxt = RESET_PC;
                state_nxt  = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (redirect) begin
                    // Data arriving now is from the wrong path; drop it and fetch the target.
                    addr_pc    = redir_tgt;
                    req_pc_nxt = redir_tgt;
                end else if (stall) begin
                    upd     = FD_HOLD;
                    f_valid = 1'b1;
                    f_pc    = req_pc;
                    f_inst  = imem_rdata;
                end else begin
                    upd        = FD_LOAD;
                    f_valid    = 1'b1;
                    f_pc       = req_pc;
                    f_inst     = imem_rdata;
                    addr_pc    = pc_inc;
                    req_pc_nxt = pc_inc;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign imem_addr = addr_pc[IMEM_AW+1:2];
    assign fd_update = upd;

    // Upper PC bits beyond the memory window are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_pc[31:IMEM_AW+2], addr_pc[1:0]};

`ifdef FETCH_PERF_EN
    fetch_perf u_perf (
        .clk          (clk),
        .rstn         (rstn),
        .run          (state == RUN),
        .fd_update    (upd),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0x100 and 0xFFFF_FFF8) with
// bench-side sync-read memories; expectations queued at drive time, popped at negedge.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_a = 1'b0;
    logic        rstn_b = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [14:0] addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] pc_a, pc_b, inst_a, inst_b;
    logic        valid_a, valid_b;
    logic [1:0]  upd_a, upd_b;
`ifdef FETCH_PERF_EN
    logic [31:0] pf_a, ps_a, pl_a;
    logic [31:0] unused_pf_b, unused_ps_b, unused_pl_b;
`endif

    int vectors = 0;
    int miscompares = 0;
    int step_no = 0;

    function automatic logic [31:0] inst_of(input logic [14:0] w);
        return {w, 2'b11, w} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        rdata_a <= inst_of(addr_a);
        rdata_b <= inst_of(addr_b);
    end

    fetch_unit #(.RESET_PC(32'h0000_0100), .IMEM_AW(15)) u_a (
        .clk         (clk),
        .rstn        (rstn_a),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (addr_a),
        .imem_rdata  (rdata_a),
        .f_pc        (pc_a),
        .f_inst      (inst_a),
        .f_valid     (valid_a),
        .fd_update   (upd_a)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(pf_a),
        .perf_stall  (ps_a),
        .perf_flush  (pl_a)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(15)) u_b (
        .clk         (clk),
        .rstn        (rstn_b),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (addr_b),
        .imem_rdata  (rdata_b),
        .f_pc        (pc_b),
        .f_inst      (inst_b),
        .f_valid     (valid_b),
        .fd_update   (upd_b)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(unused_pf_b),
        .perf_stall  (unused_ps_b),
        .perf_flush  (unused_pl_b)
`endif
    );

    typedef struct {
        int          dut;
        logic [1:0]  upd;
        logic        v;
        logic [31:0] pc;
        bit          pchk;
        logic [14:0] addr;
        bit          achk;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] FLUSH = 2'b10;

    // One clock cycle: drive inputs after the edge, queue the expectation, check at negedge.
    task automatic step(input int dut, input bit rn, input bit st, input bit rd,
                        input logic [31:0] rpc, input bit hl,
                        input logic [1:0] eu, input bit ev, input logic [31:0] epc,
                        input bit pchk, input logic [14:0] eaddr, input bit achk);
        exp_t        e;
        exp_t        g;
        logic [1:0]  o_upd;
        logic        o_v;
        logic [31:0] o_pc, o_inst, e_inst;
        logic [14:0] o_addr;
        @(posedge clk);
        #1;
        if (dut == 0) rstn_a = rn;
        else          rstn_b = rn;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        e.dut = dut; e.upd = eu; e.v = ev; e.pc = epc; e.pchk = pchk;
        e.addr = eaddr; e.achk = achk;
        sb.push_back(e);
        @(negedge clk);
        step_no++;
        g      = sb.pop_front();
        o_upd  = (g.dut == 0) ? upd_a   : upd_b;
        o_v    = (g.dut == 0) ? valid_a : valid_b;
        o_pc   = (g.dut == 0) ? pc_a    : pc_b;
        o_inst = (g.dut == 0) ? inst_a  : inst_b;
        o_addr = (g.dut == 0) ? addr_a  : addr_b;
        e_inst = g.v ? inst_of(g.pc[16:2]) : 32'h0;

        vectors++;
        assert (o_upd === g.upd) else begin
            miscompares++;
            $error("FAIL fd_update step %0d: observed %b expected %b", step_no, o_upd, g.upd);
        end
        vectors++;
        assert (o_v === g.v) else begin
            miscompares++;
            $error("FAIL f_valid step %0d: observed %b expected %b", step_no, o_v, g.v);
        end
        vectors++;
        assert (o_inst === e_inst) else begin
            miscompares++;
            $error("FAIL f_inst step %0d: observed %h expected %h", step_no, o_inst, e_inst);
        end
        if (g.pchk) begin
            vectors++;
            assert (o_pc === g.pc) else begin
                miscompares++;
                $error("FAIL f_pc step %0d: observed %h expected %h", step_no, o_pc, g.pc);
            end
        end
        if (g.achk) begin
            vectors++;
            assert (o_addr === g.addr) else begin
                miscompares++;
                $error("FAIL imem_addr step %0d: observed %h expected %h", step_no, o_addr, g.addr);
            end
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic check_perf(input logic [31:0] ef, input logic [31:0] es, input logic [31:0] el);
        vectors++;
        assert (pf_a === ef) else begin
            miscompares++;
            $error("FAIL perf_fetched step %0d: observed %0d expected %0d", step_no, pf_a, ef);
        end
        vectors++;
        assert (ps_a === es) else begin
            miscompares++;
            $error("FAIL perf_stall step %0d: observed %0d expected %0d", step_no, ps_a, es);
        end
        vectors++;
        assert (pl_a === el) else begin
            miscompares++;
            $error("FAIL perf_flush step %0d: observed %0d expected %0d", step_no, pl_a, el);
        end
    endtask
`endif

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        // dut rn st rd rpc hl | upd v pc pchk addr achk
        step(0, 1, 0, 0, 32'h0,   0, FLUSH, 0, 32'h0,   1, 15'h040, 1); // BOOT
        step(0, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'h100, 1, 15'h041, 1);
        step(0, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'h104, 1, 15'h042, 1);
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 0, 32'h0, 0, HOLD, 1, 32'h108, 1, 15'h042, 1);
        step(0, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'h108, 1, 15'h043, 1);
        step(0, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'h10C, 1, 15'h044, 1);
        // Redirect with simultaneous stall; low address bits must be dropped.
        step(0, 1, 1, 1, 32'h203, 0, FLUSH, 0, 32'h0,   0, 15'h080, 1);
        step(0, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'h200, 1, 15'h081, 1);
        for (int i = 1; i < 6; i++)
            step(0, 1, 0, 0, 32'h0, 0, LOAD, 1, 32'h200 + 32'(4 * i), 1, 15'h081 + 15'(i), 1);
        // Halt and redirect together: halt wins.
        step(0, 1, 0, 1, 32'h400, 1, FLUSH, 0, 32'h0,   0, 15'h0,   0);
`ifdef FETCH_PERF_EN
        check_perf(32'd10, 32'd3, 32'd1);
`endif
        step(0, 1, 0, 1, 32'h400, 0, FLUSH, 0, 32'h0,   1, 15'h0,   0);
        step(0, 1, 1, 0, 32'h0,   1, FLUSH, 0, 32'h0,   1, 15'h0,   0);
        step(0, 1, 0, 0, 32'h0,   0, FLUSH, 0, 32'h0,   1, 15'h0,   0);
`ifdef FETCH_PERF_EN
        check_perf(32'd10, 32'd3, 32'd2);
`endif
        // Reset out of HALTED restarts at RESET_PC.
        step(0, 0, 0, 0, 32'h0,   0, FLUSH, 0, 32'h0,   1, 15'h0,   0);
        step(0, 1, 0, 0, 32'h0,   0, FLUSH, 0, 32'h0,   1, 15'h040, 1);
`ifdef FETCH_PERF_EN
        check_perf(32'd0, 32'd0, 32'd0);
`endif
        step(0, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'h100, 1, 15'h041, 1);
        // Second instance: PC wrap through 2^32.
        step(1, 1, 0, 0, 32'h0,   0, FLUSH, 0, 32'h0,        1, 15'h7FFE, 1);
        step(1, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'hFFFF_FFF8, 1, 15'h7FFF, 1);
        step(1, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'hFFFF_FFFC, 1, 15'h0000, 1);
        step(1, 1, 0, 0, 32'h0,   0, LOAD,  1, 32'h0000_0000, 1, 15'h0001, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
